// File: rtl/envelope_generator_multi.sv
// Time-multiplexed multi-voice ADSR envelope generator: one adder, one exp lookup
// and one multiplier shared across VOICES slots, per-voice state in register arrays.

module eight_bit_exponential_decay_lookup (
    input  logic [7:0] x,
    output logic [7:0] y
);
    // Piecewise-linear exponential: halves every 32 input steps, y(0) = 255,
    // monotonically non-increasing across the whole range.
    logic [7:0]  base;
    logic [12:0] prod;

    always_comb begin
        base = 8'd255 >> x[7:5];
        prod = {5'b0, base} * {8'b0, x[4:0]};
        y    = base - 8'(prod >> 6);
    end
endmodule

module envelope_generator_multi #(
    parameter int VOICES           = 4,
    parameter int ACCUMULATOR_BITS = 26,
    parameter int INC_BITS         = 17,
    parameter bit RETRIGGER        = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VOICES-1:0]     gate,
    input  logic [INC_BITS-1:0]   attack_inc,
    input  logic [INC_BITS-1:0]   decay_inc,
    input  logic [INC_BITS-1:0]   release_inc,
    input  logic [7:0]            sustain_level,
    output logic [8*VOICES-1:0]   amplitude,
    output logic [VOICES-1:0]     is_idle
);
    localparam int SW   = $clog2(VOICES);
    localparam int AW   = ACCUMULATOR_BITS + 1;
    localparam int SUMW = ((AW > INC_BITS) ? AW : INC_BITS) + 1;

    typedef enum logic [2:0] {S_OFF, S_ATTACK, S_DECAY, S_SUSTAIN, S_RELEASE} state_t;

    logic [SW-1:0]   slot_q, slot_d;
    state_t          state_q [VOICES];
    state_t          state_d [VOICES];
    logic [AW-1:0]   acc_q   [VOICES];
    logic [AW-1:0]   acc_d   [VOICES];
    logic [7:0]      amp_q   [VOICES];
    logic [7:0]      amp_d   [VOICES];
    logic [7:0]      rel_q   [VOICES];
    logic [7:0]      rel_d   [VOICES];
    logic [VOICES-1:0] prev_gate_q, prev_gate_d;
    logic [VOICES-1:0] idle_q, idle_d;

    state_t          st, nst;
    logic [AW-1:0]   acc_cur, nacc;
    logic [7:0]      amp_cur, namp, rel_cur, nrel;
    logic [INC_BITS-1:0] inc_cur;
    logic [SUMW-1:0] sum;
    logic            ovf, g, pg, rising, falling, retrig_ok;
    logic [7:0]      top, e_val, mul_b, scaled;
    logic [15:0]     prod;

    eight_bit_exponential_decay_lookup u_exp (.x(top), .y(e_val));

    always_comb begin
        st      = state_q[slot_q];
        acc_cur = acc_q[slot_q];
        amp_cur = amp_q[slot_q];
        rel_cur = rel_q[slot_q];
        g       = gate[slot_q];
        pg      = prev_gate_q[slot_q];
        rising  = g & ~pg;
        falling = ~g & pg;
        retrig_ok = (st == S_OFF) || (st == S_RELEASE) || RETRIGGER;

        case (st)
            S_ATTACK:  inc_cur = attack_inc;
            S_DECAY:   inc_cur = decay_inc;
            S_RELEASE: inc_cur = release_inc;
            default:   inc_cur = '0;
        endcase
        sum = SUMW'(acc_cur) + SUMW'(inc_cur);
        ovf = (sum[SUMW-1:ACCUMULATOR_BITS] != '0) || (inc_cur == '0);
        top = sum[ACCUMULATOR_BITS-1 -: 8];

        // The single multiplier serves both decay and release scaling.
        mul_b  = (st == S_RELEASE) ? rel_cur : 8'd255 - sustain_level;
        prod   = {8'b0, e_val} * {8'b0, mul_b};
        scaled = 8'(prod >> 8);

        nst  = st;
        nacc = acc_cur;
        namp = amp_cur;
        nrel = rel_cur;
        if (rising && retrig_ok) begin
            nst  = S_ATTACK;
            nacc = '0;
            nacc[ACCUMULATOR_BITS-1 -: 8] = amp_cur;
        end else if (falling && (st == S_ATTACK || st == S_DECAY || st == S_SUSTAIN)) begin
            nst  = S_RELEASE;
            nrel = amp_cur;
            nacc = '0;
        end else begin
            case (st)
                S_ATTACK: begin
                    if (ovf) begin namp = 8'd255; nacc = '0; nst = S_DECAY; end
                    else     begin namp = top;    nacc = AW'(sum); end
                end
                S_DECAY: begin
                    if (ovf) begin namp = sustain_level; nacc = '0; nst = S_SUSTAIN; end
                    else     begin namp = sustain_level + scaled; nacc = AW'(sum); end
                end
                S_SUSTAIN: namp = sustain_level;
                S_RELEASE: begin
                    if (ovf) begin namp = 8'd0; nacc = '0; nst = S_OFF; end
                    else     begin namp = scaled; nacc = AW'(sum); end
                end
                default: begin namp = 8'd0; nacc = '0; end
            endcase
        end

        slot_d      = (slot_q == SW'(VOICES - 1)) ? '0 : slot_q + 1'b1;
        state_d     = state_q;
        acc_d       = acc_q;
        amp_d       = amp_q;
        rel_d       = rel_q;
        prev_gate_d = prev_gate_q;
        idle_d      = idle_q;
        state_d[slot_q]     = nst;
        acc_d[slot_q]       = nacc;
        amp_d[slot_q]       = namp;
        rel_d[slot_q]       = nrel;
        prev_gate_d[slot_q] = g;
        idle_d[slot_q]      = (nst == S_OFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= '0;
            prev_gate_q <= '0;
            idle_q      <= '1;
            for (int v = 0; v < VOICES; v++) begin
                state_q[v] <= S_OFF;
                acc_q[v]   <= '0;
                amp_q[v]   <= '0;
                rel_q[v]   <= '0;
            end
        end else begin
            slot_q      <= slot_d;
            prev_gate_q <= prev_gate_d;
            idle_q      <= idle_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            amp_q       <= amp_d;
            rel_q       <= rel_d;
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_out
        assign amplitude[8*v +: 8] = amp_q[v];
    end
    assign is_idle = idle_q;
endmodule

// File: tb/tb_envelope_generator_multi.sv
// Scoreboard bench: a per-voice behavioural ADSR model predicts every cycle for a
// retrigger and a legato instance; a monitor pops and compares on the falling edge.

module tb_envelope_generator_multi;
    localparam int NV = 4;
    localparam int AB = 12;
    localparam int FULL = 1 << AB;
    localparam int OFF = 0, ATT = 1, DEC = 2, SUS = 3, REL = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NV-1:0] gate;
    logic [16:0] attack_inc, decay_inc, release_inc;
    logic [7:0] sustain_level;
    logic [8*NV-1:0] amp_r, amp_l;
    logic [NV-1:0] idle_r, idle_l;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    envelope_generator_multi #(.VOICES(NV), .ACCUMULATOR_BITS(AB), .INC_BITS(17), .RETRIGGER(1'b1)) dut_r (
        .clk(clk), .rst(rst), .gate(gate), .attack_inc(attack_inc), .decay_inc(decay_inc),
        .release_inc(release_inc), .sustain_level(sustain_level), .amplitude(amp_r), .is_idle(idle_r));

    envelope_generator_multi #(.VOICES(NV), .ACCUMULATOR_BITS(AB), .INC_BITS(17), .RETRIGGER(1'b0)) dut_l (
        .clk(clk), .rst(rst), .gate(gate), .attack_inc(attack_inc), .decay_inc(decay_inc),
        .release_inc(release_inc), .sustain_level(sustain_level), .amplitude(amp_l), .is_idle(idle_l));

    // ---------------- reference model ----------------
    typedef struct {
        logic [8*NV-1:0] amp_r, amp_l;
        logic [NV-1:0]   idle_r, idle_l;
    } exp_t;
    exp_t sb[$];

    int m_st [2][NV];
    int m_acc[2][NV];
    int m_amp[2][NV];
    int m_rel[2][NV];
    int m_pg [2][NV];
    int m_slot;

    function automatic int exp_lu(input int x);
        int base;
        base = 255 >> (x / 32);
        return base - (base * (x % 32)) / 64;
    endfunction

    task automatic model_step(input int d, input int legato);
        int v, st, inc, n, top, e, g, pg, amp, sus;
        bit ovf;
        v = m_slot;
        st = m_st[d][v];
        amp = m_amp[d][v];
        g = int'(gate[v]);
        pg = m_pg[d][v];
        sus = int'(sustain_level);
        inc = (st == ATT) ? int'(attack_inc) : (st == DEC) ? int'(decay_inc) :
              (st == REL) ? int'(release_inc) : 0;
        n = m_acc[d][v] + inc;
        ovf = (n >= FULL) || (inc == 0);
        top = (n >> (AB - 8)) % 256;
        e = exp_lu(top);
        if (g == 1 && pg == 0 && (st == OFF || st == REL || legato == 0)) begin
            m_st[d][v] = ATT;
            m_acc[d][v] = amp * (1 << (AB - 8));
        end else if (g == 0 && pg == 1 && (st == ATT || st == DEC || st == SUS)) begin
            m_st[d][v] = REL;
            m_rel[d][v] = amp;
            m_acc[d][v] = 0;
        end else begin
            case (st)
                ATT: if (ovf) begin m_amp[d][v] = 255; m_acc[d][v] = 0; m_st[d][v] = DEC; end
                     else begin m_amp[d][v] = top; m_acc[d][v] = n; end
                DEC: if (ovf) begin m_amp[d][v] = sus; m_acc[d][v] = 0; m_st[d][v] = SUS; end
                     else begin m_amp[d][v] = sus + (e * (255 - sus)) / 256; m_acc[d][v] = n; end
                SUS: m_amp[d][v] = sus;
                REL: if (ovf) begin m_amp[d][v] = 0; m_acc[d][v] = 0; m_st[d][v] = OFF; end
                     else begin m_amp[d][v] = (e * m_rel[d][v]) / 256; m_acc[d][v] = n; end
                default: begin m_amp[d][v] = 0; m_acc[d][v] = 0; end
            endcase
        end
        m_pg[d][v] = g;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_slot = 0;
            for (int d = 0; d < 2; d++)
                for (int v = 0; v < NV; v++) begin
                    m_st[d][v] = OFF; m_acc[d][v] = 0; m_amp[d][v] = 0;
                    m_rel[d][v] = 0; m_pg[d][v] = 0;
                end
            sb.delete();
        end else begin
            exp_t ex;
            model_step(0, 0);
            model_step(1, 1);
            m_slot = (m_slot + 1) % NV;
            for (int v = 0; v < NV; v++) begin
                ex.amp_r[8*v +: 8] = 8'(m_amp[0][v]);
                ex.amp_l[8*v +: 8] = 8'(m_amp[1][v]);
                ex.idle_r[v] = (m_st[0][v] == OFF);
                ex.idle_l[v] = (m_st[1][v] == OFF);
            end
            sb.push_back(ex);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            exp_t ex;
            ex = sb.pop_front();
            total++;
            if (amp_r !== ex.amp_r || idle_r !== ex.idle_r) begin
                bad++;
                $display("FAIL retrig_lanes t=%0t got amp=%h idle=%b want amp=%h idle=%b",
                         $time, amp_r, idle_r, ex.amp_r, ex.idle_r);
            end
            total++;
            if (amp_l !== ex.amp_l || idle_l !== ex.idle_l) begin
                bad++;
                $display("FAIL legato_lanes t=%0t got amp=%h idle=%b want amp=%h idle=%b",
                         $time, amp_l, idle_l, ex.amp_l, ex.idle_l);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic wait_amp0(input int val, input int budget, input string name);
        bit hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk);
            if (int'(amp_r[7:0]) == val) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s amp0=%0d never reached %0d in %0d cycles", name, amp_r[7:0], val, budget);
        end
    endtask

    task automatic wait_idle(input logic [NV-1:0] mask, input int budget, input string name);
        bit hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk);
            if ((idle_r & mask) == mask) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s idle=%b mask=%b not idle in %0d cycles", name, idle_r, mask, budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int prev, mn;
        bit mono;
        rst = 1'b1;
        gate = '0;
        attack_inc = 17'd256;
        decay_inc = 17'd512;
        release_inc = 17'd64;
        sustain_level = 8'd100;
        #1;
        check("reset_amp_r", 64'(amp_r), 64'd0);
        check("reset_idle_r", 64'(idle_r), 64'hF);
        check("reset_amp_l", 64'(amp_l), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Attack ramp then decay to sustain on voice 0
        @(posedge clk); #1 gate = 4'b0001;
        wait_amp0(128, 80, "attack_mid");
        check("attack_idle_mask", 64'(idle_r), 64'b1110);
        wait_amp0(255, 60, "attack_top");
        mono = 1'b1;
        prev = 255;
        for (int k = 0; k < 60 && prev != 100; k++) begin
            @(negedge clk);
            if (int'(amp_r[7:0]) > prev) mono = 1'b0;
            prev = int'(amp_r[7:0]);
        end
        check("decay_monotonic", 64'(mono), 64'd1);
        check("decay_reaches_sustain", 64'(prev), 64'd100);
        repeat (12) @(negedge clk);
        check("sustain_hold", 64'(amp_r[7:0]), 64'd100);
        sustain_level = 8'd60;
        wait_amp0(60, 5, "sustain_live_change");

        // Release to idle, then early instant release from mid-attack
        gate = 4'b0000;
        wait_idle(4'b0001, 400, "release_to_idle");
        release_inc = 17'd0;
        gate = 4'b0001;
        wait_amp0(128, 80, "attack_to_128");
        gate = 4'b0000;
        wait_idle(4'b0001, 12, "instant_release");
        check("instant_release_amp", 64'(amp_r[7:0]), 64'd0);

        // Retrigger through a one-slot gate dip from sustain
        release_inc = 17'd64;
        sustain_level = 8'd100;
        gate = 4'b0001;
        wait_amp0(100, 200, "to_sustain_100");
        repeat (8) @(negedge clk);
        gate[0] = 1'b0;
        repeat (4) @(negedge clk);
        gate[0] = 1'b1;
        mn = 255;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (int'(amp_r[7:0]) < mn) mn = int'(amp_r[7:0]);
        end
        check("retrigger_no_drop", 64'(mn >= 90), 64'd1);

        // Random independence phase across all voices
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 15) == 0) gate[$urandom_range(0, NV - 1)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0)
                attack_inc = ($urandom_range(0, 7) == 0) ? 17'd0 : 17'($urandom_range(1, 1500));
            if ($urandom_range(0, 63) == 0)
                decay_inc = ($urandom_range(0, 7) == 0) ? 17'd0 : 17'($urandom_range(1, 1500));
            if ($urandom_range(0, 63) == 0)
                release_inc = ($urandom_range(0, 7) == 0) ? 17'd0 : 17'($urandom_range(1, 1500));
            if ($urandom_range(0, 127) == 0) sustain_level = 8'($urandom_range(0, 255));
        end

        // Async reset mid-decay, then fresh attack with gate still held
        gate = 4'b0000;
        release_inc = 17'd512;
        wait_idle(4'b1111, 200, "all_idle");
        attack_inc = 17'd1024;
        decay_inc = 17'd64;
        gate = 4'b0001;
        wait_amp0(255, 40, "fast_attack");
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_amp_r", 64'(amp_r), 64'd0);
        check("async_rst_idle_r", 64'(idle_r), 64'hF);
        check("async_rst_amp_l", 64'(amp_l), 64'd0);
        check("async_rst_idle_l", 64'(idle_l), 64'hF);
        @(negedge clk) rst = 1'b0;
        attack_inc = 17'd256;
        wait_amp0(16, 12, "fresh_attack_from_zero");

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
